conv2d_addr_gen: RTL and testbench
==================================

Name: conv2d_addr_gen

Overview:
Programmable address/lane-mask sequencer for the 2D convolution engine. It walks every output position, input channel, filter row and VECTOR_SIZE-wide filter-column chunk, emitting data-RAM and filter-RAM element addresses plus a lane-enable mask and an end-of-dot-product flag on a valid/ready stream into the banked RAM read pipeline. It is the next generation of the fixed row/column/base counter chain: it adds configurable stride, multiple input channels, base addresses, backpressure and configuration error detection.

Parameters:
CNT_WIDTH, 12, width of every dimension/counter input (rows, cols, channels)
ADDR_WIDTH, 16, element address width; all address arithmetic is modulo 2^ADDR_WIDTH
VECTOR_SIZE, 8, lanes per beat (power of 2, >=2)
STRIDE_WIDTH, 4, width of stride input

Ports:
clkIn  in  1  clock
rstIn  in  1  synchronous active-high reset
startIn  in  1  start pulse; sampled only in IDLE
dataRowsIn  in  CNT_WIDTH  input feature map rows
dataColsIn  in  CNT_WIDTH  input feature map cols
filtRowsIn  in  CNT_WIDTH  filter rows
filtColsIn  in  CNT_WIDTH  filter cols
numChanIn  in  CNT_WIDTH  input channels
strideIn  in  STRIDE_WIDTH  row and column stride
dataBaseIn  in  ADDR_WIDTH  element address of data[chan0][0][0]
filtBaseIn  in  ADDR_WIDTH  element address of filt[chan0][0][0]
busyOut  out  1  high from the cycle after start is accepted until return to IDLE
doneOut  out  1  one-cycle pulse after the final beat is accepted
errorOut  out  1  one-cycle pulse on an illegal configuration
validOut  out  1  beat valid
readyIn  in  1  downstream ready
dataAddrOut  out  ADDR_WIDTH  data element address for lane 0
filtAddrOut  out  ADDR_WIDTH  filter element address for lane 0
maskOut  out  VECTOR_SIZE  lane enables; bit i means lane i is valid
lastOut  out  1  final beat of one output position's dot product

Behaviour:
- Reset: state IDLE; busyOut, doneOut, errorOut, validOut, lastOut = 0; maskOut, addresses = 0. Reset mid-run aborts: no done/error pulse, validOut low the cycle after rstIn.
- All config inputs are latched on the IDLE cycle where startIn=1; later changes are ignored until the next IDLE. startIn is ignored outside IDLE.
- States: IDLE -> CHECK (start) -> RUN (legal) or IDLE with errorOut pulse (illegal) -> DONE -> IDLE.
- Illegal configuration: any dimension = 0, strideIn = 0, filtRows > dataRows or filtCols > dataCols. No beats are emitted. errorOut is high in the cycle after CHECK (start at cycle N -> errorOut at N+2), and busyOut drops at the same time.
- Latency: start sampled at cycle N -> CHECK at N+1 -> first validOut at N+2.
- Loop order, innermost first:
  - fc: 0, V, 2V... while fc < filtCols.
  - fr: 0..filtRows-1.
  - ch: 0..numChan-1.
  - outCol position oc: 0, S, 2S... while oc + filtCols <= dataCols.
  - outRow position orw: same rule against dataRows.
  - V = VECTOR_SIZE, S = stride.
- Addresses per beat:
  - dataAddr = dataBase + ch*dataRows*dataCols + (orw+fr)*dataCols + oc + fc
  - filtAddr = filtBase + ch*filtRows*filtCols + fr*filtCols + fc
  - Implement with incremental accumulators, not per-beat multipliers. Results must be bit-exact modulo 2^ADDR_WIDTH.
- maskOut bit i = (fc + i < filtCols).
- lastOut = 1 on the beat with the final fc, final fr and final ch.
- Handshake:
  - A beat transfers when validOut & readyIn. While validOut=1 and readyIn=0, all beat outputs hold stable.
  - validOut never drops without a transfer. readyIn is ignored when validOut=0.
  - Back-to-back transfers sustain one beat per cycle.
- The final beat is accepted at cycle M -> DONE at M+1, with doneOut=1 and validOut=0 in that cycle. IDLE and busyOut=0 follow at M+2. A start in that IDLE cycle is accepted.
- Counter widths must not overflow for dimensions up to 2^CNT_WIDTH-1. Position comparisons use CNT_WIDTH+1 bits.

Test Plan:
1. Basic 4x4 data, 3x3 filter, 1 channel, stride 1, V=8, dataBase 0, filtBase 0x100, readyIn=1 -> 12 beats, all maskOut=0x07.
   - Beat 0: data 0, filt 0x100, last 0.
   - Beat 2: data 8, filt 0x106, last 1.
   - Beat 3: data 1, filt 0x100.
   - Beat 11: data 13.
   - doneOut one cycle after beat 11.
2. Wide filter: 2x12 data, 2x10 filter, stride 1 -> 3 output positions x 2 rows x 2 chunks = 12 beats.
   - Chunk masks alternate 0xFF, 0x03.
   - Second chunk address = first + 8.
   - last only on the fr=1 second chunk.
3. Stride 2: 5x5 data, 3x3 filter -> output positions (0,0), (0,2), (2,0), (2,2).
   - First data addresses 0, 2, 10, 12.
   - 12 beats total.
4. Channels: numChan 2, 4x4 data, 3x3 filter -> 24 beats.
   - The ch=1 beat for position (0,0) has data 16, filt filtBase+9.
   - last only after the ch=1 fr=2 beat.
5. Backpressure: readyIn low for 5 cycles mid-run, then random toggling -> outputs held while stalled, no beat lost or duplicated; sequence identical to test 1.
6. Errors and reset:
   - filtRows 5 > dataRows 4 -> errorOut at N+2, no validOut, no doneOut.
   - strideIn 0 -> same.
   - rstIn asserted mid-run -> validOut 0 next cycle, no doneOut; the next start runs cleanly from beat 0.

Source files
------------

// File: rtl/conv2d_addr_gen.sv
// conv2d_addr_gen: address and lane-mask sequencer for the 2D convolution engine.
//
// Walks output rows, output cols, input channels, filter rows and VECTOR_SIZE-wide
// filter-column chunks (innermost last in that list), emitting one beat per step on a
// valid/ready stream. Addresses come from incremental accumulators; the only products
// (plane size, stride*cols) are formed once while checking the configuration.
//
// Ports:
//   clkIn, rstIn           clock, synchronous active-high reset
//   startIn                start pulse, sampled only in IDLE (config latched then)
//   dataRowsIn..numChanIn  feature map / filter dimensions and channel count
//   strideIn               row and column stride
//   dataBaseIn, filtBaseIn element base addresses of channel 0
//   busyOut                high from the cycle after start until return to IDLE
//   doneOut, errorOut      one-cycle completion / illegal-configuration pulses
//   validOut, readyIn      beat handshake
//   dataAddrOut            data element address of lane 0
//   filtAddrOut            filter element address of lane 0
//   maskOut                lane enables
//   lastOut                final beat of one output position's dot product
module conv2d_addr_gen #(
  parameter int unsigned CNT_WIDTH    = 12,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned VECTOR_SIZE  = 8,
  parameter int unsigned STRIDE_WIDTH = 4
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic                    startIn,
  input  logic [CNT_WIDTH-1:0]    dataRowsIn,
  input  logic [CNT_WIDTH-1:0]    dataColsIn,
  input  logic [CNT_WIDTH-1:0]    filtRowsIn,
  input  logic [CNT_WIDTH-1:0]    filtColsIn,
  input  logic [CNT_WIDTH-1:0]    numChanIn,
  input  logic [STRIDE_WIDTH-1:0] strideIn,
  input  logic [ADDR_WIDTH-1:0]   dataBaseIn,
  input  logic [ADDR_WIDTH-1:0]   filtBaseIn,
  output logic                    busyOut,
  output logic                    doneOut,
  output logic                    errorOut,
  output logic                    validOut,
  input  logic                    readyIn,
  output logic [ADDR_WIDTH-1:0]   dataAddrOut,
  output logic [ADDR_WIDTH-1:0]   filtAddrOut,
  output logic [VECTOR_SIZE-1:0]  maskOut,
  output logic                    lastOut
);

  // One extra bit so column/position sums never wrap for maximal dimensions.
  localparam int unsigned CW = CNT_WIDTH + 1;
  localparam logic [CW-1:0] VecStep = CW'(VECTOR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] VecAddr = ADDR_WIDTH'(VECTOR_SIZE);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StCheck, StRun, StDone} stateT;

  stateT stateQ;

  // Latched configuration.
  logic [CNT_WIDTH-1:0]    dataRowsQ, dataColsQ, filtRowsQ, filtColsQ, numChanQ;
  logic [STRIDE_WIDTH-1:0] strideQ;
  logic [ADDR_WIDTH-1:0]   dataBaseQ, filtBaseQ;
  logic [ADDR_WIDTH-1:0]   planeQ;    // dataRows*dataCols
  logic [ADDR_WIDTH-1:0]   rowStepQ;  // stride*dataCols

  // Loop counters. Output positions are tracked by their end (pos + filter size).
  logic [CW-1:0]        fcQ;
  logic [CNT_WIDTH-1:0] frQ, chQ;
  logic [CW-1:0]        ocEndQ, orEndQ;

  // Address accumulators, outermost to innermost.
  logic [ADDR_WIDTH-1:0] rowStartQ;    // dataBase + orw*dataCols
  logic [ADDR_WIDTH-1:0] posBaseQ;     // + oc
  logic [ADDR_WIDTH-1:0] chanBaseQ;    // + ch*plane
  logic [ADDR_WIDTH-1:0] rowBaseQ;     // + fr*dataCols
  logic [ADDR_WIDTH-1:0] filtRowBaseQ; // filtBase + ch*fr*fc + fr*filtCols

  logic                   fcLast, frLast, chLast, ocLast, orLast;
  logic [CW-1:0]          nFc, strideExt;
  logic [CNT_WIDTH-1:0]   nFr, nCh;
  logic [VECTOR_SIZE-1:0] nMask;
  logic                   nLast, firstLast, cfgLegal, xfer;
  logic [ADDR_WIDTH-1:0]  colsA, filtColsA, strideA;

  function automatic logic [VECTOR_SIZE-1:0] laneMask(input logic [CW-1:0] fc,
                                                     input logic [CNT_WIDTH-1:0] cols);
    logic [VECTOR_SIZE-1:0] m;
    m = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      m[i] = (fc + CW'(i)) < CW'(cols);
    end
    return m;
  endfunction

  always_comb begin
    strideExt = CW'(strideQ);
    colsA     = ADDR_WIDTH'(dataColsQ);
    filtColsA = ADDR_WIDTH'(filtColsQ);
    strideA   = ADDR_WIDTH'(strideQ);

    fcLast = (fcQ + VecStep) >= CW'(filtColsQ);
    frLast = (frQ + CntOne) == filtRowsQ;
    chLast = (chQ + CntOne) == numChanQ;
    ocLast = (ocEndQ + strideExt) > CW'(dataColsQ);
    orLast = (orEndQ + strideExt) > CW'(dataRowsQ);

    nFc = fcLast ? '0 : fcQ + VecStep;
    nFr = !fcLast ? frQ : (frLast ? '0 : frQ + CntOne);
    nCh = !(fcLast && frLast) ? chQ : (chLast ? '0 : chQ + CntOne);

    nMask = laneMask(nFc, filtColsQ);
    nLast = ((nFc + VecStep) >= CW'(filtColsQ)) && ((nFr + CntOne) == filtRowsQ) &&
            ((nCh + CntOne) == numChanQ);
    firstLast = (VecStep >= CW'(filtColsQ)) && (filtRowsQ == CntOne) &&
                (numChanQ == CntOne);

    cfgLegal = (dataRowsQ != '0) && (dataColsQ != '0) && (filtRowsQ != '0) &&
               (filtColsQ != '0) && (numChanQ != '0) && (strideQ != '0) &&
               (filtRowsQ <= dataRowsQ) && (filtColsQ <= dataColsQ);

    xfer = validOut && readyIn;
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      stateQ       <= StIdle;
      busyOut      <= 1'b0;
      doneOut      <= 1'b0;
      errorOut     <= 1'b0;
      validOut     <= 1'b0;
      lastOut      <= 1'b0;
      maskOut      <= '0;
      dataAddrOut  <= '0;
      filtAddrOut  <= '0;
      dataRowsQ    <= '0;
      dataColsQ    <= '0;
      filtRowsQ    <= '0;
      filtColsQ    <= '0;
      numChanQ     <= '0;
      strideQ      <= '0;
      dataBaseQ    <= '0;
      filtBaseQ    <= '0;
      planeQ       <= '0;
      rowStepQ     <= '0;
      fcQ          <= '0;
      frQ          <= '0;
      chQ          <= '0;
      ocEndQ       <= '0;
      orEndQ       <= '0;
      rowStartQ    <= '0;
      posBaseQ     <= '0;
      chanBaseQ    <= '0;
      rowBaseQ     <= '0;
      filtRowBaseQ <= '0;
    end else begin
      doneOut  <= 1'b0;
      errorOut <= 1'b0;
      unique case (stateQ)
        StIdle: begin
          if (startIn) begin
            dataRowsQ <= dataRowsIn;
            dataColsQ <= dataColsIn;
            filtRowsQ <= filtRowsIn;
            filtColsQ <= filtColsIn;
            numChanQ  <= numChanIn;
            strideQ   <= strideIn;
            dataBaseQ <= dataBaseIn;
            filtBaseQ <= filtBaseIn;
            busyOut   <= 1'b1;
            stateQ    <= StCheck;
          end
        end

        StCheck: begin
          if (!cfgLegal) begin
            errorOut <= 1'b1;
            busyOut  <= 1'b0;
            stateQ   <= StIdle;
          end else begin
            planeQ       <= ADDR_WIDTH'(dataRowsQ) * ADDR_WIDTH'(dataColsQ);
            rowStepQ     <= strideA * colsA;
            fcQ          <= '0;
            frQ          <= '0;
            chQ          <= '0;
            ocEndQ       <= CW'(filtColsQ);
            orEndQ       <= CW'(filtRowsQ);
            rowStartQ    <= dataBaseQ;
            posBaseQ     <= dataBaseQ;
            chanBaseQ    <= dataBaseQ;
            rowBaseQ     <= dataBaseQ;
            filtRowBaseQ <= filtBaseQ;
            dataAddrOut  <= dataBaseQ;
            filtAddrOut  <= filtBaseQ;
            maskOut      <= laneMask('0, filtColsQ);
            lastOut      <= firstLast;
            validOut     <= 1'b1;
            stateQ       <= StRun;
          end
        end

        StRun: begin
          // Beat outputs only move on a transfer, so they hold while stalled.
          if (xfer) begin
            fcQ     <= nFc;
            frQ     <= nFr;
            chQ     <= nCh;
            maskOut <= nMask;
            lastOut <= nLast;
            if (!fcLast) begin
              dataAddrOut <= dataAddrOut + VecAddr;
              filtAddrOut <= filtAddrOut + VecAddr;
            end else if (!frLast) begin
              rowBaseQ     <= rowBaseQ + colsA;
              dataAddrOut  <= rowBaseQ + colsA;
              filtRowBaseQ <= filtRowBaseQ + filtColsA;
              filtAddrOut  <= filtRowBaseQ + filtColsA;
            end else if (!chLast) begin
              // Filter channels are contiguous, so the row base just keeps stepping.
              chanBaseQ    <= chanBaseQ + planeQ;
              rowBaseQ     <= chanBaseQ + planeQ;
              dataAddrOut  <= chanBaseQ + planeQ;
              filtRowBaseQ <= filtRowBaseQ + filtColsA;
              filtAddrOut  <= filtRowBaseQ + filtColsA;
            end else if (!ocLast) begin
              ocEndQ       <= ocEndQ + strideExt;
              posBaseQ     <= posBaseQ + strideA;
              chanBaseQ    <= posBaseQ + strideA;
              rowBaseQ     <= posBaseQ + strideA;
              dataAddrOut  <= posBaseQ + strideA;
              filtRowBaseQ <= filtBaseQ;
              filtAddrOut  <= filtBaseQ;
            end else if (!orLast) begin
              ocEndQ       <= CW'(filtColsQ);
              orEndQ       <= orEndQ + strideExt;
              rowStartQ    <= rowStartQ + rowStepQ;
              posBaseQ     <= rowStartQ + rowStepQ;
              chanBaseQ    <= rowStartQ + rowStepQ;
              rowBaseQ     <= rowStartQ + rowStepQ;
              dataAddrOut  <= rowStartQ + rowStepQ;
              filtRowBaseQ <= filtBaseQ;
              filtAddrOut  <= filtBaseQ;
            end else begin
              validOut <= 1'b0;
              lastOut  <= 1'b0;
              maskOut  <= '0;
              doneOut  <= 1'b1;
              stateQ   <= StDone;
            end
          end
        end

        StDone: begin
          busyOut <= 1'b0;
          stateQ  <= StIdle;
        end

        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_addr_gen.sv
// Self-checking bench for conv2d_addr_gen: directed cases plus randomized configurations
// and random backpressure, checked against a nested-loop reference model.
module tb_conv2d_addr_gen;

  localparam int CntW  = 12;
  localparam int AddrW = 16;
  localparam int Vec   = 8;
  localparam int StrW  = 4;

  logic             clkIn = 1'b0;
  logic             rstIn, startIn, readyIn;
  logic [CntW-1:0]  dataRowsIn, dataColsIn, filtRowsIn, filtColsIn, numChanIn;
  logic [StrW-1:0]  strideIn;
  logic [AddrW-1:0] dataBaseIn, filtBaseIn;
  logic             busyOut, doneOut, errorOut, validOut, lastOut;
  logic [AddrW-1:0] dataAddrOut, filtAddrOut;
  logic [Vec-1:0]   maskOut;

  int nTests = 0;
  int nFail  = 0;
  int expData[$], expFilt[$], expMask[$], expLast[$];

  conv2d_addr_gen #(
    .CNT_WIDTH   (CntW),
    .ADDR_WIDTH  (AddrW),
    .VECTOR_SIZE (Vec),
    .STRIDE_WIDTH(StrW)
  ) dut (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .startIn    (startIn),
    .dataRowsIn (dataRowsIn),
    .dataColsIn (dataColsIn),
    .filtRowsIn (filtRowsIn),
    .filtColsIn (filtColsIn),
    .numChanIn  (numChanIn),
    .strideIn   (strideIn),
    .dataBaseIn (dataBaseIn),
    .filtBaseIn (filtBaseIn),
    .busyOut    (busyOut),
    .doneOut    (doneOut),
    .errorOut   (errorOut),
    .validOut   (validOut),
    .readyIn    (readyIn),
    .dataAddrOut(dataAddrOut),
    .filtAddrOut(filtAddrOut),
    .maskOut    (maskOut),
    .lastOut    (lastOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkEq(input string tag, input int got, input int exp);
    nTests++;
    if (got != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit isLegal(input int dr, dc, fr, fc, nc, s);
    return dr != 0 && dc != 0 && fr != 0 && fc != 0 && nc != 0 && s != 0 &&
           fr <= dr && fc <= dc;
  endfunction

  // Reference: the specified loop nest and address formulas, computed directly.
  function automatic void buildModel(input int dr, dc, fr, fc, nc, s, db, fb);
    expData.delete(); expFilt.delete(); expMask.delete(); expLast.delete();
    for (int orw = 0; orw + fr <= dr; orw += s)
      for (int oc = 0; oc + fc <= dc; oc += s)
        for (int ch = 0; ch < nc; ch++)
          for (int r = 0; r < fr; r++)
            for (int c = 0; c < fc; c += Vec) begin
              int m;
              m = 0;
              for (int i = 0; i < Vec; i++) if (c + i < fc) m |= (1 << i);
              expData.push_back((db + ch * dr * dc + (orw + r) * dc + oc + c) & 'hFFFF);
              expFilt.push_back((fb + ch * fr * fc + r * fc + c) & 'hFFFF);
              expMask.push_back(m);
              expLast.push_back((c + Vec >= fc && r == fr - 1 && ch == nc - 1) ? 1 : 0);
            end
  endfunction

  task automatic driveCfg(input int dr, dc, fr, fc, nc, s, db, fb);
    dataRowsIn = CntW'(dr);
    dataColsIn = CntW'(dc);
    filtRowsIn = CntW'(fr);
    filtColsIn = CntW'(fc);
    numChanIn  = CntW'(nc);
    strideIn   = StrW'(s);
    dataBaseIn = AddrW'(db);
    filtBaseIn = AddrW'(fb);
  endtask

  task automatic runJob(input int dr, dc, fr, fc, nc, s, db, fb,
                        input bit rndReady, input int stallAt);
    bit legal;
    bit rdy;
    int idx, cyc, stall, total;
    legal = isLegal(dr, dc, fr, fc, nc, s);
    if (legal) buildModel(dr, dc, fr, fc, nc, s, db, fb);
    total = expData.size();
    @(negedge clkIn);
    driveCfg(dr, dc, fr, fc, nc, s, db, fb);
    startIn = 1'b1;
    @(negedge clkIn);
    // Now in CHECK; scrambled inputs must not affect this job.
    startIn = 1'b0;
    driveCfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom);
    checkEq("busy_in_check", int'(busyOut), 1);
    checkEq("valid_in_check", int'(validOut), 0);
    if (!legal) begin
      @(negedge clkIn);
      checkEq("error_pulse", int'(errorOut), 1);
      checkEq("error_busy", int'(busyOut), 0);
      checkEq("error_valid", int'(validOut), 0);
      repeat (3) begin
        @(negedge clkIn);
        checkEq("error_clear", int'(errorOut), 0);
        checkEq("error_no_valid", int'(validOut), 0);
        checkEq("error_no_done", int'(doneOut), 0);
      end
      return;
    end
    idx = 0; cyc = 0; stall = 0;
    while (idx < total && cyc < 4 * total + 50) begin
      @(negedge clkIn);
      cyc++;
      checkEq("valid", int'(validOut), 1);
      checkEq("done_early", int'(doneOut), 0);
      checkEq("data_addr", int'(dataAddrOut), expData[idx]);
      checkEq("filt_addr", int'(filtAddrOut), expFilt[idx]);
      checkEq("mask", int'(maskOut), expMask[idx]);
      checkEq("last", int'(lastOut), expLast[idx]);
      if (stallAt == idx && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end else if (rndReady) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      readyIn = rdy;
      if (validOut && rdy) idx++;
    end
    checkEq("beats_sent", idx, total);
    @(negedge clkIn);
    readyIn = 1'($urandom);
    checkEq("done_pulse", int'(doneOut), 1);
    checkEq("done_valid", int'(validOut), 0);
    checkEq("done_busy", int'(busyOut), 1);
    @(negedge clkIn);
    checkEq("done_clear", int'(doneOut), 0);
    checkEq("idle_busy", int'(busyOut), 0);
    checkEq("idle_valid", int'(validOut), 0);
  endtask

  task automatic resetMidRun();
    @(negedge clkIn);
    driveCfg(4, 4, 3, 3, 1, 1, 0, 'h100);
    startIn = 1'b1;
    readyIn = 1'b1;
    @(negedge clkIn);
    startIn = 1'b0;
    repeat (5) @(negedge clkIn);
    checkEq("pre_reset_valid", int'(validOut), 1);
    rstIn = 1'b1;
    @(negedge clkIn);
    rstIn = 1'b0;
    checkEq("reset_valid", int'(validOut), 0);
    checkEq("reset_busy", int'(busyOut), 0);
    checkEq("reset_done", int'(doneOut), 0);
    repeat (4) begin
      @(negedge clkIn);
      checkEq("post_reset_no_done", int'(doneOut), 0);
      checkEq("post_reset_no_valid", int'(validOut), 0);
    end
  endtask

  initial begin
    rstIn   = 1'b1;
    startIn = 1'b0;
    readyIn = 1'b0;
    driveCfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clkIn);
    checkEq("rst_busy", int'(busyOut), 0);
    checkEq("rst_done", int'(doneOut), 0);
    checkEq("rst_error", int'(errorOut), 0);
    checkEq("rst_valid", int'(validOut), 0);
    checkEq("rst_last", int'(lastOut), 0);
    checkEq("rst_mask", int'(maskOut), 0);
    checkEq("rst_data", int'(dataAddrOut), 0);
    checkEq("rst_filt", int'(filtAddrOut), 0);
    rstIn = 1'b0;

    runJob(4, 4, 3, 3, 1, 1, 0, 'h100, 1'b0, -1);   // basic
    runJob(2, 12, 2, 10, 1, 1, 0, 'h100, 1'b0, -1); // wide filter, two chunks
    runJob(5, 5, 3, 3, 1, 2, 0, 'h100, 1'b0, -1);   // stride 2
    runJob(4, 4, 3, 3, 2, 1, 0, 'h100, 1'b0, -1);   // two channels
    runJob(4, 4, 3, 3, 1, 1, 0, 'h100, 1'b1, 4);    // backpressure
    runJob(4, 4, 5, 3, 1, 1, 0, 'h100, 1'b0, -1);   // filter taller than data
    runJob(4, 4, 3, 3, 1, 0, 0, 'h100, 1'b0, -1);   // stride 0
    runJob(4, 4, 3, 3, 0, 1, 0, 'h100, 1'b0, -1);   // zero channels
    runJob(3, 7, 2, 7, 2, 1, 'hFFF0, 'hFFFC, 1'b1, -1); // address wrap
    resetMidRun();
    runJob(4, 4, 3, 3, 1, 1, 0, 'h100, 1'b0, -1);

    for (int t = 0; t < 25; t++) begin
      int dr, dc, fr, fc, nc, s;
      dr = $urandom_range(1, 6);
      dc = $urandom_range(1, 18);
      fr = $urandom_range(1, dr);
      fc = $urandom_range(1, dc);
      nc = $urandom_range(1, 2);
      s  = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) fc = dc + 1;
      runJob(dr, dc, fr, fc, nc, s, $urandom_range(0, 65535), $urandom_range(0, 65535),
             1'b1, $urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
